// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle logic/arith ops run through EXEC;
// multiply (shift-add) and divide (restoring) iterate one bit per cycle.
// The result is registered into sal on a one-cycle done pulse.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sal,
    output logic             MSB,
    output logic             zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Iteration index of the final multiply/divide step.
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [3:0]         op_sel;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res;

    logic [WIDTH:0]     mul_hi;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;

    // Opcode classes that leave the single-cycle path.
    function automatic logic is_mul(input logic [3:0] s);
        return s[3:1] == 3'b100;
    endfunction

    function automatic logic is_div(input logic [3:0] s);
        return s[3:1] == 3'b101;
    endfunction

    // Single-cycle operations; only the low SHW bits of b form a shift amount.
    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0]       s,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] r;
        sh = b[SHW-1:0];
        case (s)
            4'd0: r = a + b;
            4'd1: r = a & b;
            4'd2: r = a ^ b;
            4'd3: r = a << sh;
            4'd4: r = $unsigned($signed(a) >>> sh);
            4'd5: r = a - b;
            4'd6: begin
                r    = a + b;
                r[0] = 1'b0;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Selects which internal register feeds sal once the operation finishes.
    function automatic logic [WIDTH-1:0] pick_result(input logic [3:0]         s,
                                                     input logic [2*WIDTH-1:0] p,
                                                     input logic [WIDTH-1:0]   q,
                                                     input logic [WIDTH-1:0]   rm,
                                                     input logic [WIDTH-1:0]   r);
        logic [WIDTH-1:0] v;
        case (s)
            4'd8:    v = p[WIDTH-1:0];
            4'd9:    v = p[2*WIDTH-1:WIDTH];
            4'd10:   v = q;
            4'd11:   v = rm;
            default: v = r;
        endcase
        return v;
    endfunction

    // One shift-add step: conditionally add the multiplicand into the high half.
    always_comb begin
        mul_hi = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            mul_hi = mul_hi + {1'b0, op_a};
        end
    end

    // One restoring-division step: shift in the next dividend bit and trial-subtract.
    // A zero divisor always "fits", giving an all-ones quotient and rem = dividend.
    always_comb begin
        div_sh   = {rem, quo[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, op_b};
        div_diff = div_sh[WIDTH-1:0] - op_b;
    end

    // Control FSM with registered busy/done/sal and the iterative datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sal    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
            cnt    <= '0;
            prod   <= '0;
            quo    <= '0;
            rem    <= '0;
            res    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= rs1;
                        op_b   <= rs2;
                        op_sel <= sel;
                        cnt    <= '0;
                        prod   <= {{WIDTH{1'b0}}, rs2};
                        quo    <= rs1;
                        rem    <= '0;
                        busy   <= 1'b1;
                        if (is_mul(sel)) begin
                            state <= MUL;
                        end else if (is_div(sel)) begin
                            state <= DIV;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    res   <= alu_op(op_sel, op_a, op_b);
                    busy  <= 1'b0;
                    state <= DONE;
                end
                MUL: begin
                    prod <= {mul_hi, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DIV: begin
                    rem  <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                    quo  <= {quo[WIDTH-2:0], div_ge};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    sal   <= pick_result(op_sel, prod, quo, rem, res);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags follow the registered result directly.
    assign MSB  = sal[WIDTH-1];
    assign zero = (sal == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
// The driver pushes model results; a negedge monitor pops them on done.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1;
    logic [3:0]  sel0, sel1;
    logic [31:0] a0, b0;
    logic [7:0]  a1, b1;
    logic        busy0, busy1, done0, done1, msb0, msb1, zero0, zero1;
    logic [31:0] sal0;
    logic [7:0]  sal1;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sel(sel0), .rs1(a0), .rs2(b0),
        .busy(busy0), .done(done0), .sal(sal0), .MSB(msb0), .zero(zero0)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sel(sel1), .rs1(a1), .rs2(b1),
        .busy(busy1), .done(done1), .sal(sal1), .MSB(msb1), .zero(zero1)
    );

    typedef struct {
        logic [63:0] val;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] last_sal[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain arithmetic on masked integers.
    function automatic logic [63:0] ref_model(input int w, input logic [3:0] s,
                                              input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]  m, a, b, r;
        logic [127:0] p;
        int           sh;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a  = a_in & m;
        b  = b_in & m;
        sh = int'(b % 64'(w));
        p  = {64'd0, a} * {64'd0, b};
        case (s)
            4'd0:  r = a + b;
            4'd1:  r = a & b;
            4'd2:  r = a ^ b;
            4'd3:  r = a << sh;
            4'd4: begin
                r = a >> sh;
                if (a[w-1]) r = r | (m & ~(m >> sh));
            end
            4'd5:  r = a - b;
            4'd6:  r = (a + b) & ~64'd1;
            4'd8:  r = p[63:0];
            4'd9:  r = 64'(p >> w);
            4'd10: r = (b == 64'd0) ? m : a / b;
            4'd11: r = (b == 64'd0) ? a : a % b;
            default: r = 64'd0;
        endcase
        return r & m;
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] out_sal(input int d);
        return (d == 0) ? {32'd0, sal0} : {56'd0, sal1};
    endfunction
    function automatic logic [63:0] out_done(input int d);
        return {63'd0, (d == 0) ? done0 : done1};
    endfunction
    function automatic logic [63:0] out_busy(input int d);
        return {63'd0, (d == 0) ? busy0 : busy1};
    endfunction
    function automatic logic [63:0] out_msb(input int d);
        return {63'd0, (d == 0) ? msb0 : msb1};
    endfunction
    function automatic logic [63:0] out_zero(input int d);
        return {63'd0, (d == 0) ? zero0 : zero1};
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input int d, input logic st, input logic [3:0] s,
                         input logic [63:0] a, input logic [63:0] b);
        if (d == 0) begin
            start0 = st; sel0 = s; a0 = a[31:0]; b0 = b[31:0];
        end else begin
            start1 = st; sel1 = s; a1 = a[7:0]; b1 = b[7:0];
        end
    endtask

    // Monitor: on done compare against the oldest expectation, else sal must hold.
    task automatic monitor(input int d);
        exp_t e;
        int   w;
        w = width_of(d);
        if (out_done(d) == 64'd1) begin
            check("busy_with_done", out_busy(d), 64'd0);
            if (qsize(d) == 0) begin
                n_chk++;
                $display("FAIL unexpected_done dut%0d: done=1, expected no pending op", d);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check("sal", out_sal(d), e.val);
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
                check("msb", out_msb(d), {63'd0, e.val[w-1]});
                check("zero", out_zero(d), {63'd0, e.val == 64'd0});
            end
            last_sal[d] = out_sal(d);
        end else begin
            check("sal_stable", out_sal(d), last_sal[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_sal[0] = 64'd0;
            last_sal[1] = 64'd0;
        end else begin
            for (int d = 0; d < 2; d++) monitor(d);
        end
    end

    // Present one op at the next rising edge and record its expected result.
    task automatic issue(input int d, input logic [3:0] s, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   w;
        w = width_of(d);
        drive(d, 1'b1, s, a, b);
        @(posedge clk);
        #1;
        e.val = ref_model(w, s, a, b);
        e.lat = (s >= 4'd8 && s <= 4'd11) ? w + 1 : 2;
        e.t0  = cyc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        drive(d, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 200; i++) begin
            if (qsize(d) == 0) return;
            @(negedge clk);
            #1;
        end
        n_chk++;
        $display("FAIL timeout dut%0d: %0d results still pending, expected 0", d, qsize(d));
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    function automatic logic [63:0] rnd_operand(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'd1 << $urandom_range(0, w - 1);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy0), 64'd0);
        check({tag, "_done"}, 64'(done0), 64'd0);
        check({tag, "_sal"},  64'(sal0),  64'd0);
        check({tag, "_zero"}, 64'(zero0), 64'd1);
        check({tag, "_msb"},  64'(msb0),  64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ds[8];
        logic [63:0] da[8];
        logic [63:0] db[8];
        ds = '{4'd0, 4'd4, 4'd6, 4'd9, 4'd8, 4'd10, 4'd11, 4'd10};
        da = '{64'hFFFFFFFF, 64'h80000000, 64'h00011001, 64'hFFFFFFFF,
               64'hFFFFFFFF, 64'd100, 64'd100, 64'd100};
        db = '{64'd1, 64'h24, 64'h2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd0, 64'd0, 64'd7};

        rst_n = 1'b0;
        drive(0, 1'b0, 4'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 4'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_done8", 64'(done1), 64'd0);
        check("reset_zero8", 64'(zero1), 64'd1);

        // Release and start on the very first edge afterwards.
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_idle(0);
            issue(0, ds[i], da[i], db[i]);
        end

        // Start hammered with fresh operands throughout a multiply.
        wait_idle(0);
        issue(0, 4'd9, {32'd0, $urandom}, {32'd0, $urandom});
        for (int k = 0; k < 31; k++) begin
            drive(0, 1'b1, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            @(posedge clk);
            #1;
            check("busy_during_mul", 64'(busy0), 64'd1);
        end
        drive(0, 1'b0, 4'd0, 64'd0, 64'd0);

        // Reset in the middle of a divide, then an add right after release.
        wait_idle(0);
        issue(0, 4'd10, {32'd0, $urandom}, {32'd0, $urandom});
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q0.delete();
        q1.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        issue(0, 4'd0, 64'h12345678, 64'h11111111);
        wait_idle(0);
        repeat (40) @(posedge clk);

        // Randomised traffic with occasional back-to-back starts.
        for (int i = 0; i < 150; i++) begin
            wait_idle(0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(0, 4'($urandom_range(0, 15)), rnd_operand(32), rnd_operand(32));
        end
        wait_idle(0);

        // Narrow instance.
        issue(1, 4'd10, 64'hFF, 64'h10);
        for (int i = 0; i < 60; i++) begin
            wait_idle(1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(1, 4'($urandom_range(0, 15)), rnd_operand(8), rnd_operand(8));
        end
        wait_idle(1);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
